// File: rtl/brew_pkg.sv
// Shared state encodings, phase codes and default durations for the brew scheduler.
// Phase codes are fixed by the downstream display/LED datapath.
package brew_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BREW  = 3'd1,
    S_STEAM = 3'd2,
    S_WAIT  = 3'd3,
    S_CLEAN = 3'd4
  } state_t;

  localparam logic [1:0] BREW_PH  = 2'b00;
  localparam logic [1:0] STEAM_PH = 2'b01;
  localparam logic [1:0] WAIT_PH  = 2'b10;
  localparam logic [1:0] CLEAN_PH = 2'b11;

  localparam int BREW_T_DEF  = 5;
  localparam int STEAM_T_DEF = 3;
  localparam int WAIT_T_DEF  = 10;
  localparam int CLEAN_T_DEF = 4;
  localparam int CNT_W_DEF   = 4;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_STEAM: return STEAM_PH;
      S_WAIT:  return WAIT_PH;
      S_CLEAN: return CLEAN_PH;
      default: return BREW_PH;
    endcase
  endfunction

  function automatic logic [3:0] led_of(input state_t s);
    case (s)
      S_BREW:  return 4'b0001;
      S_STEAM: return 4'b0010;
      S_WAIT:  return 4'b0100;
      S_CLEAN: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/brew_order_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending after index last, wrapping.
// Zero latency; vld low when nothing is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               vld
);

  always_comb begin
    winner = '0;
    vld    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!vld && pending[(int'(last) + i) % NUM_REQ]) begin
        vld    = 1'b1;
        winner = 2'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/brew_order_scheduler.sv
// Runs the brewing unit through Brew/Steam/Wait/Clean for one round-robin granted order at a time.
// All outputs registered; en=0 freezes sequencing while requests keep queueing.
module brew_order_scheduler
  import brew_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BREW_T  = BREW_T_DEF,
  parameter int STEAM_T = STEAM_T_DEF,
  parameter int WAIT_T  = WAIT_T_DEF,
  parameter int CLEAN_T = CLEAN_T_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               dividedclk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] done,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [1:0]         phase,
  output logic [3:0]         ledState,
  output logic [CNT_W-1:0]   phase_cnt,
  output logic [NUM_REQ-1:0] pending
);

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [1:0]         last, win;
  logic               win_vld, grant, finish;
  logic [NUM_REQ-1:0] arb_in, win_oh;

  function automatic logic [CNT_W-1:0] term(input int t);
    return CNT_W'(t - 1);
  endfunction

  // End of Clean also sees requests arriving on that same edge
  assign arb_in = (state == S_CLEAN) ? (pending | req) : pending;
  assign win_oh = NUM_REQ'(1) << win;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending (arb_in),
    .last    (last),
    .winner  (win),
    .vld     (win_vld)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = phase_cnt;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: grant = en & win_vld;
      S_BREW: if (en) begin
        if (phase_cnt == term(BREW_T)) begin nxt_state = S_STEAM; nxt_cnt = '0; end
        else nxt_cnt = phase_cnt + 1'b1;
      end
      S_STEAM: if (en) begin
        if (phase_cnt == term(STEAM_T)) begin nxt_state = S_WAIT; nxt_cnt = '0; end
        else nxt_cnt = phase_cnt + 1'b1;
      end
      S_WAIT: if (en) begin
        if (phase_cnt == term(WAIT_T)) begin nxt_state = S_CLEAN; nxt_cnt = '0; end
        else nxt_cnt = phase_cnt + 1'b1;
      end
      S_CLEAN: if (en) begin
        if (phase_cnt == term(CLEAN_T)) begin
          finish    = 1'b1;
          grant     = win_vld;
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else nxt_cnt = phase_cnt + 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
    if (grant) begin
      nxt_state = S_BREW;
      nxt_cnt   = '0;
    end
  end

  always_ff @(posedge dividedclk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      pending   <= '0;
      ack       <= '0;
      done      <= '0;
      grant_id  <= '0;
      last      <= 2'(NUM_REQ - 1);
      busy      <= 1'b0;
      phase     <= BREW_PH;
      ledState  <= 4'b0000;
    end else begin
      state     <= nxt_state;
      phase_cnt <= nxt_cnt;
      busy      <= (nxt_state != S_IDLE);
      phase     <= phase_of(nxt_state);
      ledState  <= led_of(nxt_state);
      // A request on the grant edge re-queues the same requester
      pending   <= (pending & ~(grant ? win_oh : '0)) | req;
      ack       <= grant ? win_oh : '0;
      done      <= finish ? (NUM_REQ'(1) << grant_id) : '0;
      if (grant) begin
        grant_id <= win;
        last     <= win;
      end
    end
  end

endmodule
